// File: rtl/tug_pkg.sv
// Shared encodings for the tug-of-war blocks: game state bus, winner code, LFSR taps.
package tug_pkg;

  typedef enum logic [1:0] {
    ST_DARK  = 2'b00,
    ST_PLAY  = 2'b10,
    ST_SCORE = 2'b01,
    ST_WIN   = 2'b11
  } tug_state_t;

  typedef enum logic [1:0] {
    W_NONE  = 2'b00,
    W_LEFT  = 2'b01,
    W_RIGHT = 2'b10
  } tug_winner_t;

  // Galois mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One Galois LFSR step
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/tug_round_referee_if.sv
// Button inputs and game-status outputs of the round referee.
interface tug_round_referee_if;
  logic                 pbl_l;
  logic                 pbl_r;
  logic                 new_game;
  tug_pkg::tug_state_t  state;
  logic signed [3:0]    pos;
  logic                 point_l;
  logic                 point_r;
  logic                 false_start;
  tug_pkg::tug_winner_t winner;

  modport master (
    output pbl_l, pbl_r, new_game,
    input  state, pos, point_l, point_r, false_start, winner
  );

  modport slave (
    input  pbl_l, pbl_r, new_game,
    output state, pos, point_l, point_r, false_start, winner
  );
endinterface

// File: rtl/tug_lfsr16.sv
// Free-running 16-bit Galois LFSR used to randomise the DARK delay.
module tug_lfsr16 import tug_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;

  // Advance every cycle; a nonzero seed keeps it off the all-zero lockup state
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= SEED;
    else     r_lfsr <= lfsr_step(r_lfsr);
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/tug_round_referee.sv
// Tug-of-war round sequencer and press arbiter.
// Optional macro TUG_REFEREE_PLAY_TIMEOUT_EN: end a PLAY round with no point
// after PLAY_TIMEOUT cycles without a press.
module tug_round_referee import tug_pkg::*; #(
  parameter int unsigned DARK_MIN        = 1500,
  parameter int unsigned DARK_RANGE_BITS = 10,
  parameter int unsigned SCORE_HOLD      = 2000,
  parameter int unsigned WIN_POS         = 3,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
`ifdef TUG_REFEREE_PLAY_TIMEOUT_EN
  , parameter int unsigned PLAY_TIMEOUT  = 4000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  tug_round_referee_if.slave bus
);

  localparam logic [15:0]       DARK_MIN_C   = 16'(DARK_MIN);
  localparam logic [15:0]       SCORE_HOLD_C = 16'(SCORE_HOLD);
  localparam logic [15:0]       DARK_RST     = DARK_MIN_C + 16'(LFSR_SEED[DARK_RANGE_BITS-1:0]);
  localparam logic signed [3:0] POS_MAX      = 4'(WIN_POS);
  localparam logic signed [3:0] POS_MIN      = -POS_MAX;
`ifdef TUG_REFEREE_PLAY_TIMEOUT_EN
  localparam logic [15:0]       PLAY_LAST    = 16'(PLAY_TIMEOUT - 1);
`endif

  tug_state_t        r_state, w_state_nxt;
  logic [15:0]       r_cnt, w_cnt_nxt;
  logic [15:0]       w_lfsr, w_dark_load;
  logic signed [3:0] r_pos, w_pos_nxt;
  tug_winner_t       r_winner, w_winner_nxt;
  logic              r_point_l, r_point_r, r_false_start;
  logic              r_tie_pri, w_tie_nxt;
  logic              w_score_l, w_score_r, w_fs, w_reload, w_tie_flip;
  logic              w_clear, w_enter_win, w_at_win, w_score_entry;
  logic              w_unused_lfsr;
`ifdef TUG_REFEREE_PLAY_TIMEOUT_EN
  logic [15:0]       r_play_cnt, w_play_cnt_nxt;
`endif

  tug_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .o_lfsr (w_lfsr)
  );

  assign w_dark_load   = DARK_MIN_C + 16'(w_lfsr[DARK_RANGE_BITS-1:0]);
  assign w_unused_lfsr = ^w_lfsr;
  assign w_at_win      = (r_pos == POS_MAX) || (r_pos == POS_MIN);
  assign w_score_entry = (w_state_nxt == ST_SCORE) && (r_state != ST_SCORE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_DARK;
    else     r_state <= w_state_nxt;
  end

  // Next-state and round events; a press always outranks expiry/timeout
  always_comb begin
    w_state_nxt = r_state;
    w_score_l   = 1'b0;
    w_score_r   = 1'b0;
    w_fs        = 1'b0;
    w_reload    = 1'b0;
    w_tie_flip  = 1'b0;
    w_clear     = 1'b0;
    w_enter_win = 1'b0;
    case (r_state)
      ST_DARK: begin
        if (bus.pbl_l && bus.pbl_r) begin
          w_fs     = 1'b1;
          w_reload = 1'b1;
        end else if (bus.pbl_l) begin
          w_fs        = 1'b1;
          w_score_r   = 1'b1;
          w_state_nxt = ST_SCORE;
        end else if (bus.pbl_r) begin
          w_fs        = 1'b1;
          w_score_l   = 1'b1;
          w_state_nxt = ST_SCORE;
        end else if (r_cnt <= 16'd1) begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (bus.pbl_l && bus.pbl_r) begin
          w_score_l   = ~r_tie_pri;
          w_score_r   = r_tie_pri;
          w_tie_flip  = 1'b1;
          w_state_nxt = ST_SCORE;
        end else if (bus.pbl_l) begin
          w_score_l   = 1'b1;
          w_state_nxt = ST_SCORE;
        end else if (bus.pbl_r) begin
          w_score_r   = 1'b1;
          w_state_nxt = ST_SCORE;
        end
`ifdef TUG_REFEREE_PLAY_TIMEOUT_EN
        else if (r_play_cnt == PLAY_LAST) begin
          w_state_nxt = ST_SCORE;
        end
`endif
      end
      ST_SCORE: begin
        if (r_cnt <= 16'd1) begin
          if (w_at_win) begin
            w_state_nxt = ST_WIN;
            w_enter_win = 1'b1;
          end else begin
            w_state_nxt = ST_DARK;
            w_reload    = 1'b1;
          end
        end
      end
      default: begin
        if (bus.new_game) begin
          w_state_nxt = ST_DARK;
          w_reload    = 1'b1;
          w_clear     = 1'b1;
        end
      end
    endcase
  end

  // Next values of rope position, winner, tie priority and round counters
  always_comb begin
    w_pos_nxt    = r_pos;
    w_winner_nxt = r_winner;
    w_tie_nxt    = r_tie_pri;
    w_cnt_nxt    = r_cnt;
    if (w_clear) begin
      w_pos_nxt    = 4'sd0;
      w_winner_nxt = W_NONE;
    end else if (w_score_l && (r_pos != POS_MIN)) begin
      w_pos_nxt = r_pos - 4'sd1;
    end else if (w_score_r && (r_pos != POS_MAX)) begin
      w_pos_nxt = r_pos + 4'sd1;
    end
    if (w_enter_win) w_winner_nxt = r_pos[3] ? W_LEFT : W_RIGHT;
    if (w_tie_flip)  w_tie_nxt    = ~r_tie_pri;
    if (w_reload)             w_cnt_nxt = w_dark_load;
    else if (w_score_entry)   w_cnt_nxt = SCORE_HOLD_C;
    else if (r_cnt != 16'd0)  w_cnt_nxt = r_cnt - 16'd1;
`ifdef TUG_REFEREE_PLAY_TIMEOUT_EN
    w_play_cnt_nxt = (r_state == ST_PLAY) ? r_play_cnt + 16'd1 : 16'd0;
`endif
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= DARK_RST;
      r_pos         <= 4'sd0;
      r_winner      <= W_NONE;
      r_point_l     <= 1'b0;
      r_point_r     <= 1'b0;
      r_false_start <= 1'b0;
      r_tie_pri     <= 1'b0;
`ifdef TUG_REFEREE_PLAY_TIMEOUT_EN
      r_play_cnt    <= 16'd0;
`endif
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_pos         <= w_pos_nxt;
      r_winner      <= w_winner_nxt;
      r_point_l     <= w_score_l;
      r_point_r     <= w_score_r;
      r_false_start <= w_fs;
      r_tie_pri     <= w_tie_nxt;
`ifdef TUG_REFEREE_PLAY_TIMEOUT_EN
      r_play_cnt    <= w_play_cnt_nxt;
`endif
    end
  end

  assign bus.state       = r_state;
  assign bus.pos         = r_pos;
  assign bus.winner      = r_winner;
  assign bus.point_l     = r_point_l;
  assign bus.point_r     = r_point_r;
  assign bus.false_start = r_false_start;

endmodule

// File: tb/tb_tug_round_referee.sv
// Directed bench for tug_round_referee (DARK_MIN=8, DARK_RANGE_BITS=2, SCORE_HOLD=4, WIN_POS=3).
module tb_tug_round_referee;
  import tug_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  tug_round_referee_if bus_if ();

  tug_round_referee #(
    .DARK_MIN        (8),
    .DARK_RANGE_BITS (2),
    .SCORE_HOLD      (4),
    .WIN_POS         (3),
    .LFSR_SEED       (16'hACE1)
`ifdef TUG_REFEREE_PLAY_TIMEOUT_EN
    , .PLAY_TIMEOUT  (5)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic l, input logic r);
    bus_if.pbl_l = l;
    bus_if.pbl_r = r;
    step();
    bus_if.pbl_l = 1'b0;
    bus_if.pbl_r = 1'b0;
  endtask

  task automatic wait_state(input string tag, input tug_state_t exp, input int max_cyc);
    int n;
    n = 0;
    while (bus_if.state !== exp && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, 32'(bus_if.state), 32'(exp));
  endtask

  // Wait for PLAY, press two cycles in, and check the scoring cycle
  task automatic play_round(input string tag, input logic l, input logic r,
                            input int exp_pl, input int exp_pr, input int exp_pos);
    wait_state({tag, "_wait_play"}, ST_PLAY, 30);
    step();
    press(l, r);
    check({tag, "_state"},   32'(bus_if.state), 32'(ST_SCORE));
    check({tag, "_point_l"}, 32'(bus_if.point_l), exp_pl);
    check({tag, "_point_r"}, 32'(bus_if.point_r), exp_pr);
    check({tag, "_pos"},     32'(bus_if.pos), exp_pos);
    check({tag, "_fs"},      32'(bus_if.false_start), 0);
  endtask

  initial begin
    int n;
    int bad;
    n_checks        = 0;
    n_err           = 0;
    rst             = 1'b1;
    bus_if.pbl_l    = 1'b0;
    bus_if.pbl_r    = 1'b0;
    bus_if.new_game = 1'b0;
    repeat (3) step();

    // Reset values
    check("rst_state",   32'(bus_if.state), 32'(ST_DARK));
    check("rst_pos",     32'(bus_if.pos), 0);
    check("rst_point_l", 32'(bus_if.point_l), 0);
    check("rst_point_r", 32'(bus_if.point_r), 0);
    check("rst_fs",      32'(bus_if.false_start), 0);
    check("rst_winner",  32'(bus_if.winner), 32'(W_NONE));
    rst = 1'b0;

    // First DARK duration lies in DARK_MIN..DARK_MIN+3
    n = 0;
    while (bus_if.state === ST_DARK && n < 30) begin
      step();
      n++;
    end
    check("dark_len_in_range", 32'(n >= 8 && n <= 11), 1);
    check("dark_to_play", 32'(bus_if.state), 32'(ST_PLAY));

`ifdef TUG_REFEREE_PLAY_TIMEOUT_EN
    // Timeout: SCORE after 5 PLAY cycles, no point
    repeat (4) step();
    check("to_still_play", 32'(bus_if.state), 32'(ST_PLAY));
    step();
    check("to_state", 32'(bus_if.state), 32'(ST_SCORE));
    check("to_pos",   32'(bus_if.pos), 0);
    check("to_pulse", 32'(bus_if.point_l | bus_if.point_r), 0);
`else
    // PLAY holds indefinitely with no presses
    bad = 0;
    repeat (20) begin
      step();
      if (bus_if.state !== ST_PLAY || bus_if.pos !== 4'sd0 ||
          bus_if.point_l || bus_if.point_r || bus_if.false_start) bad++;
    end
    check("play_hold", bad, 0);
`endif

    // Left press in PLAY, then SCORE lasts 4 cycles
    play_round("left_play", 1'b1, 1'b0, 1, 0, -1);
    step();
    check("left_pulse_one_cycle", 32'(bus_if.point_l), 0);
    check("left_score_hold",      32'(bus_if.state), 32'(ST_SCORE));
    repeat (2) step();
    check("left_score_hold_end",  32'(bus_if.state), 32'(ST_SCORE));
    step();
    check("left_back_to_dark",    32'(bus_if.state), 32'(ST_DARK));
    check("left_pos_kept",        32'(bus_if.pos), -1);

    // Right false start 3 cycles into DARK: left scores
    repeat (2) step();
    press(1'b0, 1'b1);
    check("fs_r_flag",    32'(bus_if.false_start), 1);
    check("fs_r_point_l", 32'(bus_if.point_l), 1);
    check("fs_r_point_r", 32'(bus_if.point_r), 0);
    check("fs_r_pos",     32'(bus_if.pos), -2);
    check("fs_r_state",   32'(bus_if.state), 32'(ST_SCORE));

    // Both pressed in DARK: false start, no point, stay DARK
    wait_state("fs_both_wait_dark", ST_DARK, 10);
    press(1'b1, 1'b1);
    check("fs_both_flag",  32'(bus_if.false_start), 1);
    check("fs_both_state", 32'(bus_if.state), 32'(ST_DARK));
    check("fs_both_pos",   32'(bus_if.pos), -2);
    check("fs_both_pts",   32'(bus_if.point_l | bus_if.point_r), 0);
    step();
    check("fs_both_clear", 32'(bus_if.false_start), 0);

    // Right point, then two ties: left first, then right
    play_round("right_a", 1'b0, 1'b1, 0, 1, -1);
    play_round("tie_1",   1'b1, 1'b1, 1, 0, -2);
    play_round("tie_2",   1'b1, 1'b1, 0, 1, -1);

    // Right wins up to +3, then WIN
    play_round("run_0", 1'b0, 1'b1, 0, 1, 0);
    play_round("run_1", 1'b0, 1'b1, 0, 1, 1);
    play_round("run_2", 1'b0, 1'b1, 0, 1, 2);
    play_round("run_3", 1'b0, 1'b1, 0, 1, 3);
    wait_state("win_enter", ST_WIN, 10);
    check("win_winner", 32'(bus_if.winner), 32'(W_RIGHT));
    check("win_pos",    32'(bus_if.pos), 3);
    press(1'b1, 1'b1);
    check("win_ignore_state", 32'(bus_if.state), 32'(ST_WIN));
    check("win_ignore_pos",   32'(bus_if.pos), 3);
    check("win_ignore_pulse", 32'(bus_if.point_l | bus_if.point_r | bus_if.false_start), 0);
    bus_if.new_game = 1'b1;
    step();
    bus_if.new_game = 1'b0;
    check("ng_state",  32'(bus_if.state), 32'(ST_DARK));
    check("ng_pos",    32'(bus_if.pos), 0);
    check("ng_winner", 32'(bus_if.winner), 32'(W_NONE));

    // new_game outside WIN has no effect
    step();
    bus_if.new_game = 1'b1;
    step();
    bus_if.new_game = 1'b0;
    check("ng_ignored_state", 32'(bus_if.state), 32'(ST_DARK));
    check("ng_ignored_pos",   32'(bus_if.pos), 0);

    // Reach +2, then reset in the middle of PLAY
    play_round("pre_rst_1", 1'b0, 1'b1, 0, 1, 1);
    play_round("pre_rst_2", 1'b0, 1'b1, 0, 1, 2);
    wait_state("rst_wait_play", ST_PLAY, 30);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_state",  32'(bus_if.state), 32'(ST_DARK));
    check("mid_rst_pos",    32'(bus_if.pos), 0);
    check("mid_rst_winner", 32'(bus_if.winner), 32'(W_NONE));
    check("mid_rst_pulse",  32'(bus_if.point_l | bus_if.point_r | bus_if.false_start), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tug_round_referee.md
Name: tug_round_referee

Overview:
- Round sequencer and press arbiter for the tug-of-war game.
- Drives the shared 2-bit game `state` bus consumed by the AI and display blocks: DARK, then a pseudo-random delay, then PLAY.
- Arbitrates left/right button presses: first valid press wins the round; presses during DARK are false starts.
- Moves the rope position, holds a score display, and declares a game winner.

Parameters:
- DARK_MIN, 1500, minimum DARK duration in clk cycles.
- DARK_RANGE_BITS, 10, LFSR bits added to DARK_MIN; DARK lasts DARK_MIN..DARK_MIN+2^DARK_RANGE_BITS-1 cycles.
- SCORE_HOLD, 2000, SCORE state duration in cycles.
- WIN_POS, 3, absolute rope position that ends the game (1..7).
- LFSR_SEED, 16'hACE1, reset value of the LFSR; must be nonzero.
- PLAY_TIMEOUT, 4000, PLAY cycles before a no-point round (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pbl_l  in  1  left press, single-cycle pulse, already synchronised
- pbl_r  in  1  right press (player or pbl_AI, OR'd upstream), single-cycle pulse
- new_game  in  1  pulse; restarts the game from WIN
- state  out  2  00 DARK, 10 PLAY, 01 SCORE, 11 WIN
- pos  out  4  signed rope position, -WIN_POS..+WIN_POS; negative = left leading
- point_l  out  1  one-cycle pulse, left scored
- point_r  out  1  one-cycle pulse, right scored
- false_start  out  1  one-cycle pulse, a press occurred in DARK
- winner  out  2  00 none, 01 left, 10 right; valid in WIN

Behaviour:
- Reset (synchronous): state=DARK, pos=0, all pulses 0, winner=00, LFSR=LFSR_SEED, tie_pri=left, dark_cnt=DARK_MIN+LFSR_SEED[DARK_RANGE_BITS-1:0].
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, advances every cycle in every state.
- Each entry to DARK reloads dark_cnt = DARK_MIN + lfsr[DARK_RANGE_BITS-1:0]. Counter width is 16 bits; DARK_MIN+2^DARK_RANGE_BITS must be <= 65535.
- DARK:
  - dark_cnt decrements each cycle.
  - A press in DARK is a false start: false_start=1 next cycle and the opponent scores. pbl_l alone gives +1; pbl_r alone gives -1. Go to SCORE.
  - Both pressed in the same cycle: false_start=1, no point, stay in DARK, reload dark_cnt.
  - A press takes priority over expiry in the same cycle.
  - dark_cnt reaching 0 with no press: go to PLAY next cycle.
- PLAY:
  - First press wins. pbl_l gives pos-1 and point_l; pbl_r gives pos+1 and point_r. Go to SCORE.
  - Simultaneous presses: the winner is tie_pri, then tie_pri toggles (round-robin tie-break).
  - Point pulses are asserted in the first SCORE cycle.
- SCORE:
  - Holds SCORE_HOLD cycles; all presses ignored.
  - Then, if |pos|==WIN_POS, go to WIN with winner=sign(pos). Otherwise go to DARK.
- WIN:
  - Presses ignored.
  - new_game gives pos=0, winner=00, state=DARK next cycle; dark_cnt reloads.
- new_game outside WIN is ignored.
- pos saturates at ±WIN_POS. It can never exceed the limit because WIN is entered first.
- rst asserted in any state returns to the reset values on the next clock edge. Mid-round presses are lost.
- Latency: press to state=SCORE and point pulse is 1 cycle.

Optional Feature:
- Macro: TUG_REFEREE_PLAY_TIMEOUT_EN.
- Defined: a play_cnt counts PLAY cycles. When it reaches PLAY_TIMEOUT with no press, the FSM goes to SCORE with no point and no pulse, pos unchanged. A press takes priority over the timeout in the same cycle.
- Undefined: PLAY waits indefinitely; no play_cnt logic.

Decomposition:
- Shared package tug_pkg holds:
  - state encodings ST_DARK=2'b00, ST_PLAY=2'b10, ST_SCORE=2'b01, ST_WIN=2'b11 (shared with the AI and display blocks);
  - winner encodings W_NONE, W_LEFT, W_RIGHT;
  - the LFSR tap constant.
- One sub-module: tug_lfsr16, with clk, rst, seed parameter and 16-bit output.

Test Plan:
- Params for all tests: DARK_MIN=8, DARK_RANGE_BITS=2, SCORE_HOLD=4, WIN_POS=3.
- Reset, no presses: state=00 for 8..11 cycles, then 10, held indefinitely. All pulses 0, pos=0.
- pbl_l pulse 2 cycles into PLAY: next cycle state=01, point_l=1 for 1 cycle, pos=-1. After 4 cycles state=00.
- pbl_r pulse 3 cycles into DARK: false_start=1, point_l=1, pos=-1, state=01. Then pbl_l+pbl_r together in DARK: false_start=1, pos unchanged, state stays 00.
- Simultaneous pbl_l+pbl_r in PLAY twice: first round the left scores (pos=-1), second round the right scores (pos=0).
- Three right wins in PLAY: pos=+3; after SCORE, state=11, winner=10. Presses ignored. new_game: pos=0, winner=00, state=00.
- rst asserted mid-PLAY at pos=+2: next cycle state=00, pos=0. With TUG_REFEREE_PLAY_TIMEOUT_EN and PLAY_TIMEOUT=5: no press gives SCORE after 5 PLAY cycles with pos unchanged.
